// File: rtl/pong_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : pong_if
// Description : Scan position, sync, game-state and pixel-output bundle
//               between the timing/game side and pong_renderer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pong_if;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] sq_xpos;
    logic [9:0] sq_ypos;
    logic [9:0] pdl1_xpos;
    logic [9:0] pdl1_ypos;
    logic [9:0] pdl2_xpos;
    logic [9:0] pdl2_ypos;
    logic       sq_shown;
    logic       game_over;
    logic       game_startup;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hsync_out;
    logic       vsync_out;

    modport master (
        output h_count, v_count, video_on, hsync_in, vsync_in,
        output sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos,
        output sq_shown, game_over, game_startup, score_p1, score_p2,
        input  red, green, blue, hsync_out, vsync_out
    );

    modport slave (
        input  h_count, v_count, video_on, hsync_in, vsync_in,
        input  sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos,
        input  sq_shown, game_over, game_startup, score_p1, score_p2,
        output red, green, blue, hsync_out, vsync_out
    );
endinterface
`default_nettype wire

// File: rtl/pong_renderer.sv
`default_nettype none
// ============================================================================
// Module      : pong_renderer
// Description : Frame-coherent 2-stage Pong pixel renderer (RGB444 + syncs).
//               Optional macro SCORE_DISPLAY_EN adds 7-segment score glyphs.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_renderer #(
    parameter int H_VIDEO    = 640,
    parameter int V_VIDEO    = 480,
    parameter int SQ_WIDTH   = 16,
    parameter int PDL_WIDTH  = 12,
    parameter int PDL_HEIGHT = 96,
    parameter int NET_SEG    = 16,
    parameter int BORDER_W   = 8
) (
    input  logic   clk_0,
    input  logic   rst,
    pong_if.slave  bus
);
    localparam int          c_net_bit = $clog2(NET_SEG);
    localparam logic [10:0] c_net_l   = 11'(H_VIDEO / 2 - 1);
    localparam logic [10:0] c_net_r   = 11'(H_VIDEO / 2);

    function automatic logic in_span(input logic [10:0] p, input logic [10:0] lo, input int len);
        return (p >= lo) && (p < lo + 11'(len));
    endfunction

    logic [9:0] r_sq_x, r_sq_y, r_pdl1_x, r_pdl1_y, r_pdl2_x, r_pdl2_y;
    logic       r_sq_shown, r_game_over, r_game_startup;
    logic [5:0] r_frame_cnt;

    logic       r_sq_hit, r_pdl_hit, r_net_hit, r_border_hit;
    logic       r_video_on_d, r_hsync_d, r_vsync_d;
    logic [11:0] r_rgb;
    logic       r_hsync_out, r_vsync_out;

    logic [10:0] w_h, w_v;
    logic        w_snapshot, w_sq_hit, w_pdl_hit, w_net_hit, w_border_hit;
    logic        w_score_d;
    logic [11:0] w_rgb;

    assign w_h        = {1'b0, bus.h_count};
    assign w_v        = {1'b0, bus.v_count};
    assign w_snapshot = (bus.h_count == 10'd0) && (bus.v_count == 10'(V_VIDEO));

    // Game state is only sampled once per frame, in the vertical blank.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            r_sq_x         <= 10'd320;
            r_sq_y         <= 10'd240;
            r_pdl1_x       <= 10'd24;
            r_pdl1_y       <= 10'd191;
            r_pdl2_x       <= 10'd603;
            r_pdl2_y       <= 10'd191;
            r_sq_shown     <= 1'b0;
            r_game_over    <= 1'b0;
            r_game_startup <= 1'b1;
            r_frame_cnt    <= 6'd0;
        end else if (w_snapshot) begin
            r_sq_x         <= bus.sq_xpos;
            r_sq_y         <= bus.sq_ypos;
            r_pdl1_x       <= bus.pdl1_xpos;
            r_pdl1_y       <= bus.pdl1_ypos;
            r_pdl2_x       <= bus.pdl2_xpos;
            r_pdl2_y       <= bus.pdl2_ypos;
            r_sq_shown     <= bus.sq_shown;
            r_game_over    <= bus.game_over;
            r_game_startup <= bus.game_startup;
            r_frame_cnt    <= r_frame_cnt + 6'd1;
        end
    end

    assign w_sq_hit  = r_sq_shown
                     && in_span(w_h, {1'b0, r_sq_x}, SQ_WIDTH)
                     && in_span(w_v, {1'b0, r_sq_y}, SQ_WIDTH);
    assign w_pdl_hit = (in_span(w_h, {1'b0, r_pdl1_x}, PDL_WIDTH)
                        && in_span(w_v, {1'b0, r_pdl1_y}, PDL_HEIGHT))
                     || (in_span(w_h, {1'b0, r_pdl2_x}, PDL_WIDTH)
                        && in_span(w_v, {1'b0, r_pdl2_y}, PDL_HEIGHT));
    // Net is a dashed two-pixel column; it blinks on the startup menu.
    assign w_net_hit = ((w_h == c_net_l) || (w_h == c_net_r))
                     && !bus.v_count[c_net_bit]
                     && (!r_game_startup || r_frame_cnt[5]);
    assign w_border_hit = r_game_over && r_frame_cnt[5]
                     && ((w_h < 11'(BORDER_W)) || (w_h >= 11'(H_VIDEO - BORDER_W))
                      || (w_v < 11'(BORDER_W)) || (w_v >= 11'(V_VIDEO - BORDER_W)));

`ifdef SCORE_DISPLAY_EN
    localparam logic [10:0] c_score1_x = 11'd280;
    localparam logic [10:0] c_score2_x = 11'd340;
    localparam logic [10:0] c_score_y  = 11'd16;

    logic [3:0] r_score_p1, r_score_p2;
    logic       r_score_hit;
    logic       w_score_hit;

    // Segment bit order is {g,f,e,d,c,b,a}; values 10-15 add a leading "1" bar.
    function automatic logic glyph_hit(input logic [10:0] h, input logic [10:0] v,
                                       input logic [10:0] x0, input logic [3:0] val);
        logic [3:0]  d;
        logic [6:0]  s;
        logic [10:0] dx, dy;
        logic        in_box, bar;
        d  = (val >= 4'd10) ? (val - 4'd10) : val;
        case (d)
            4'd0: s = 7'h3F; 4'd1: s = 7'h06; 4'd2: s = 7'h5B; 4'd3: s = 7'h4F;
            4'd4: s = 7'h66; 4'd5: s = 7'h6D; 4'd6: s = 7'h7D; 4'd7: s = 7'h07;
            4'd8: s = 7'h7F; 4'd9: s = 7'h6F; default: s = 7'h00;
        endcase
        dx     = h - x0;
        dy     = v - c_score_y;
        in_box = in_span(h, x0, 20) && in_span(v, c_score_y, 36);
        bar    = (val >= 4'd10) && in_span(h, x0 - 11'd8, 4) && in_span(v, c_score_y, 36);
        return bar || (in_box && (
                   (s[0] && dy < 11'd4)
                || (s[1] && dx >= 11'd16 && dy < 11'd20)
                || (s[2] && dx >= 11'd16 && dy >= 11'd16)
                || (s[3] && dy >= 11'd32)
                || (s[4] && dx < 11'd4 && dy >= 11'd16)
                || (s[5] && dx < 11'd4 && dy < 11'd20)
                || (s[6] && dy >= 11'd16 && dy < 11'd20)));
    endfunction

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            r_score_p1 <= 4'd0;
            r_score_p2 <= 4'd0;
        end else if (w_snapshot) begin
            r_score_p1 <= bus.score_p1;
            r_score_p2 <= bus.score_p2;
        end
    end

    assign w_score_hit = glyph_hit(w_h, w_v, c_score1_x, r_score_p1)
                      || glyph_hit(w_h, w_v, c_score2_x, r_score_p2);

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) r_score_hit <= 1'b0;
        else      r_score_hit <= w_score_hit;
    end

    assign w_score_d = r_score_hit;
`else
    logic [7:0] w_unused_scores;
    assign w_unused_scores = {bus.score_p1, bus.score_p2};
    assign w_score_d       = 1'b0;
`endif

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            r_sq_hit     <= 1'b0;
            r_pdl_hit    <= 1'b0;
            r_net_hit    <= 1'b0;
            r_border_hit <= 1'b0;
            r_video_on_d <= 1'b0;
            r_hsync_d    <= 1'b1;
            r_vsync_d    <= 1'b1;
        end else begin
            r_sq_hit     <= w_sq_hit;
            r_pdl_hit    <= w_pdl_hit;
            r_net_hit    <= w_net_hit;
            r_border_hit <= w_border_hit;
            r_video_on_d <= bus.video_on;
            r_hsync_d    <= bus.hsync_in;
            r_vsync_d    <= bus.vsync_in;
        end
    end

    always_comb begin
        w_rgb = 12'h000;
        if (!r_video_on_d)                         w_rgb = 12'h000;
        else if (r_sq_hit || w_score_d || r_pdl_hit) w_rgb = 12'hFFF;
        else if (r_border_hit)                     w_rgb = 12'hF00;
        else if (r_net_hit)                        w_rgb = 12'h888;
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            r_rgb       <= 12'h000;
            r_hsync_out <= 1'b1;
            r_vsync_out <= 1'b1;
        end else begin
            r_rgb       <= w_rgb;
            r_hsync_out <= r_hsync_d;
            r_vsync_out <= r_vsync_d;
        end
    end

    assign bus.red       = r_rgb[11:8];
    assign bus.green     = r_rgb[7:4];
    assign bus.blue      = r_rgb[3:0];
    assign bus.hsync_out = r_hsync_out;
    assign bus.vsync_out = r_vsync_out;
endmodule
`default_nettype wire
